// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_scanout
// Brief    : Avalon-MM read master streaming one frame of pixels in raster
//            order through a credit-gated FIFO. Optional double buffering via
//            SCANOUT_DOUBLE_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_scanout #(
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter logic [25:0] BASE_ADDR   = 26'h0,
`ifdef SCANOUT_DOUBLE_BUFFER_EN
    parameter logic [25:0] BASE_ADDR_B = 26'h12C000,
`endif
    parameter int          FIFO_LOG2   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
`ifdef SCANOUT_DOUBLE_BUFFER_EN
    input  logic        buffer_select,
`endif
    output logic        busy,
    output logic        frame_done,
    output logic [25:0] master_address,
    output logic        master_read,
    output logic [3:0]  master_byteenable,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    input  logic        master_waitrequest,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        pixel_sof,
    output logic        pixel_eol,
    output logic        rsp_err
);

    localparam int c_NPIX  = H_RES * V_RES;
    localparam int c_IDXW  = $clog2(c_NPIX);
    localparam int c_OXW   = $clog2(H_RES);
    localparam int c_OYW   = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int c_DEPTH = 2 ** FIFO_LOG2;
    localparam int c_CW    = FIFO_LOG2 + 1;

    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NPIX - 1);
    localparam logic [c_OXW-1:0]  c_LAST_OX  = c_OXW'(H_RES - 1);
    localparam logic [c_OYW-1:0]  c_LAST_OY  = c_OYW'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_read;
    logic [25:0]          r_addr;
    logic [c_IDXW-1:0]    r_n;
    logic [c_CW-1:0]      r_outstanding;
    logic [c_CW-1:0]      r_count;
    logic [FIFO_LOG2-1:0] r_wptr;
    logic [FIFO_LOG2-1:0] r_rptr;
    logic [23:0]          r_mem [c_DEPTH];
    logic [c_OXW-1:0]     r_ox;
    logic [c_OYW-1:0]     r_oy;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_rsp_err;

    logic                 w_valid;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_stray;
    logic                 w_pop;
    logic [c_CW-1:0]      w_out_next;
    logic [c_CW-1:0]      w_cnt_next;
    logic                 w_credit;
    logic                 w_last_pixel;
    logic [25:0]          w_start_base;
    logic                 w_unused_rdata;

`ifdef SCANOUT_DOUBLE_BUFFER_EN
    assign w_start_base = buffer_select ? BASE_ADDR_B : BASE_ADDR;
`else
    assign w_start_base = BASE_ADDR;
`endif

    assign w_unused_rdata = ^master_readdata[31:24];

    assign w_valid      = (r_count != '0);
    assign w_accept     = r_read && !master_waitrequest;
    assign w_push       = master_readdatavalid && (r_outstanding != '0);
    assign w_stray      = master_readdatavalid && (r_outstanding == '0);
    assign w_pop        = w_valid && pixel_ready;
    assign w_out_next   = r_outstanding + c_CW'(w_accept) - c_CW'(w_push);
    assign w_cnt_next   = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_last_pixel = (r_ox == c_LAST_OX) && (r_oy == c_LAST_OY);

    // master_read is registered, so the credit test looks at next-cycle counts;
    // every in-flight read then has a guaranteed FIFO slot when it returns.
    assign w_credit = ({1'b0, w_out_next} + {1'b0, w_cnt_next}) < (c_CW + 1)'(c_DEPTH);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= master_readdata[23:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_read        <= 1'b0;
            r_addr        <= BASE_ADDR;
            r_n           <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_ox          <= '0;
            r_oy          <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_outstanding <= w_out_next;
            r_count       <= w_cnt_next;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                if (r_ox == c_LAST_OX) begin
                    r_ox <= '0;
                    r_oy <= (r_oy == c_LAST_OY) ? '0 : r_oy + 1'b1;
                end else begin
                    r_ox <= r_ox + 1'b1;
                end
            end
            if (w_stray) begin
                r_rsp_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_read <= 1'b0;
                    if (start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                        r_addr  <= w_start_base;
                        r_n     <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_read  <= w_credit;
                    end
                end
                S_FETCH: begin
                    r_read <= w_credit;
                    if (w_accept) begin
                        r_n    <= r_n + 1'b1;
                        r_addr <= r_addr + 26'd4;
                        if (r_n == c_LAST_IDX) begin
                            r_state <= S_DRAIN;
                            r_read  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_read <= 1'b0;
                    if (w_pop && w_last_pixel) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = r_busy;
    assign frame_done        = r_frame_done;
    assign master_address    = r_addr;
    assign master_read       = r_read;
    assign master_byteenable = 4'hF;
    assign rsp_err           = r_rsp_err;
    assign pixel_valid       = w_valid;
    assign pixel_data        = w_valid ? r_mem[r_rptr] : 24'h0;
    assign pixel_sof         = w_valid && (r_ox == '0) && (r_oy == '0);
    assign pixel_eol         = w_valid && (r_ox == c_LAST_OX);

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_scanout
// Brief    : Directed bench for framebuffer_scanout (4x2 frame, 4-deep FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, frame_done, master_read, pixel_valid, pixel_sof, pixel_eol, rsp_err;
    logic [25:0] master_address;
    logic [3:0]  master_byteenable;
    logic [31:0] master_readdata;
    logic        master_readdatavalid, master_waitrequest;
    logic [23:0] pixel_data;
    logic        pixel_ready = 1'b1;
`ifdef SCANOUT_DOUBLE_BUFFER_EN
    logic        buffer_select = 1'b0;
`endif

    logic        slave_en = 1'b0;
    logic        sb_en    = 1'b0;
    logic        t_rdv    = 1'b0;
    logic [31:0] t_rdata  = 32'h0;
    logic        s_rdv    = 1'b0;
    logic [31:0] s_rdata  = 32'h0;
    logic        s_wait   = 1'b0;

    assign master_readdatavalid = slave_en ? s_rdv : t_rdv;
    assign master_readdata      = slave_en ? s_rdata : t_rdata;
    assign master_waitrequest   = slave_en ? s_wait : 1'b0;

    framebuffer_scanout #(
        .H_RES      (4),
        .V_RES      (2),
        .BASE_ADDR  (26'h100),
`ifdef SCANOUT_DOUBLE_BUFFER_EN
        .BASE_ADDR_B(26'h200),
`endif
        .FIFO_LOG2  (2)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
`ifdef SCANOUT_DOUBLE_BUFFER_EN
        .buffer_select       (buffer_select),
`endif
        .busy                (busy),
        .frame_done          (frame_done),
        .master_address      (master_address),
        .master_read         (master_read),
        .master_byteenable   (master_byteenable),
        .master_readdata     (master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_waitrequest  (master_waitrequest),
        .pixel_data          (pixel_data),
        .pixel_valid         (pixel_valid),
        .pixel_ready         (pixel_ready),
        .pixel_sof           (pixel_sof),
        .pixel_eol           (pixel_eol),
        .rsp_err             (rsp_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave / scoreboard state
    int          cyc = 0;
    int          ws_cfg = 0;
    int          lat_cfg = 1;
    int          ws_cnt = 0;
    int          s_acc_cnt = 0;
    int          sb_k = 0;
    int          sb_base = 32'h100;
    int          fd_cnt = 0;
    int          max_inflight = 0;
    logic [25:0] first_addr = 26'h0;
    logic        prev_wait = 1'b0;
    logic        prev_read = 1'b0;
    logic [25:0] prev_addr = 26'h0;
    int          q_addr[$];
    int          q_due[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Everything here decides/observes what happens at the upcoming rising edge.
    always @(negedge clock) begin
        if (sb_en && pixel_valid && pixel_ready) begin
            chk("px_data", 32'(pixel_data), 32'(sb_base + 4 * sb_k));
            chk("px_sof", 32'(pixel_sof), 32'(sb_k == 0));
            chk("px_eol", 32'(pixel_eol), 32'((sb_k % 4) == 3));
            sb_k++;
        end
        if (frame_done) fd_cnt++;
        if (slave_en) begin
            if (prev_wait && prev_read) begin
                chk("hold_read", 32'(master_read), 32'd1);
                chk("hold_addr", 32'(master_address), 32'(prev_addr));
            end
            s_rdv   = 1'b0;
            s_rdata = 32'h0;
            if (q_due.size() != 0 && q_due[0] == cyc + 1) begin
                s_rdv   = 1'b1;
                s_rdata = 32'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (master_read) begin
                if (ws_cnt < ws_cfg) begin
                    s_wait = 1'b1;
                    ws_cnt++;
                end else begin
                    s_wait = 1'b0;
                    ws_cnt = 0;
                    if (s_acc_cnt == 0) first_addr = master_address;
                    s_acc_cnt++;
                    q_addr.push_back(int'(master_address));
                    q_due.push_back(cyc + 1 + lat_cfg);
                end
            end else begin
                s_wait = 1'b0;
                ws_cnt = 0;
            end
            prev_wait = s_wait;
            prev_read = master_read;
            prev_addr = master_address;
            if (s_acc_cnt - sb_k > max_inflight) max_inflight = s_acc_cnt - sb_k;
        end else begin
            s_rdv     = 1'b0;
            s_wait    = 1'b0;
            prev_wait = 1'b0;
        end
    end

    task automatic begin_frame(input int ws, input int lat, input int base);
        ws_cfg       = ws;
        lat_cfg      = lat;
        sb_base      = base;
        s_acc_cnt    = 0;
        sb_k         = 0;
        fd_cnt       = 0;
        max_inflight = 0;
        q_addr.delete();
        q_due.delete();
        slave_en     = 1'b1;
        sb_en        = 1'b1;
        pixel_ready  = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clock); #1;
            if (frame_done) begin
                seen = 1'b1;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_read"}, 32'(master_read), 32'd0);
        chk({tag, "_addr"}, 32'(master_address), 32'h100);
        chk({tag, "_be"}, 32'(master_byteenable), 32'hF);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_valid"}, 32'(pixel_valid), 32'd0);
        chk({tag, "_sof"}, 32'(pixel_sof), 32'd0);
        chk({tag, "_eol"}, 32'(pixel_eol), 32'd0);
        chk({tag, "_data"}, 32'(pixel_data), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    typedef struct {
        logic        start;
        logic        rdv;
        logic [31:0] rdata;
        logic        exp_busy;
        logic        exp_read;
        logic [25:0] exp_addr;
        logic        chk_addr;
        logic        exp_valid;
        logic [23:0] exp_data;
        logic        exp_sof;
        logic        exp_eol;
        logic        exp_done;
    } vec_t;

    function automatic vec_t mk(logic st, logic rdv, logic [31:0] rd, logic b, logic r,
                                logic [25:0] a, logic ca, logic v, logic [23:0] d,
                                logic s, logic e, logic dn);
        mk = '{st, rdv, rd, b, r, a, ca, v, d, s, e, dn};
    endfunction

    vec_t tbl [12];

    initial begin
        // Basic frame, slave returns data=addr one cycle after each accept.
        //            st   rdv  rdata      busy read addr     ca   vld  data      sof  eol  done
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 26'h100, 1'b1, 1'b0, 24'h0,   1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 26'h104, 1'b1, 1'b0, 24'h0,   1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 26'h108, 1'b1, 1'b1, 24'h100, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 26'h10C, 1'b1, 1'b1, 24'h104, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 26'h110, 1'b1, 1'b1, 24'h108, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 32'h10C, 1'b1, 1'b1, 26'h114, 1'b1, 1'b1, 24'h10C, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 32'h110, 1'b1, 1'b1, 26'h118, 1'b1, 1'b1, 24'h110, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 32'h114, 1'b1, 1'b1, 26'h11C, 1'b1, 1'b1, 24'h114, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 32'h118, 1'b1, 1'b0, 26'h0,   1'b0, 1'b1, 24'h118, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 32'h11C, 1'b1, 1'b0, 26'h0,   1'b0, 1'b1, 24'h11C, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 26'h0,   1'b0, 1'b0, 24'h0,   1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 26'h0,   1'b0, 1'b0, 24'h0,   1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        chk_reset_values("rst");
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start   = tbl[i].start;
            t_rdv   = tbl[i].rdv;
            t_rdata = tbl[i].rdata;
            @(posedge clock); #1;
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("v%0d_read", i), 32'(master_read), 32'(tbl[i].exp_read));
            if (tbl[i].chk_addr)
                chk($sformatf("v%0d_addr", i), 32'(master_address), 32'(tbl[i].exp_addr));
            chk($sformatf("v%0d_valid", i), 32'(pixel_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("v%0d_data", i), 32'(pixel_data), 32'(tbl[i].exp_data));
                chk($sformatf("v%0d_sof", i), 32'(pixel_sof), 32'(tbl[i].exp_sof));
                chk($sformatf("v%0d_eol", i), 32'(pixel_eol), 32'(tbl[i].exp_eol));
            end
            chk($sformatf("v%0d_done", i), 32'(frame_done), 32'(tbl[i].exp_done));
        end
        start = 1'b0;
        t_rdv = 1'b0;
        chk("rsp_err_clean", 32'(rsp_err), 32'd0);

        // Stray response while idle
        t_rdv   = 1'b1;
        t_rdata = 32'h00ABCDEF;
        @(posedge clock); #1;
        t_rdv = 1'b0;
        chk("stray_err", 32'(rsp_err), 32'd1);
        chk("stray_valid", 32'(pixel_valid), 32'd0);
        @(posedge clock); #1;
        chk("stray_valid2", 32'(pixel_valid), 32'd0);
        chk("stray_err_sticky", 32'(rsp_err), 32'd1);

        // Three wait states per read
        begin_frame(3, 1, 32'h100);
        pulse_start();
        chk("ws_busy_k1", 32'(busy), 32'd1);
        chk("ws_read_k1", 32'(master_read), 32'd1);
        wait_done(400);
        @(posedge clock); #1;
        chk("ws_reads", 32'(s_acc_cnt), 32'd8);
        chk("ws_pixels", 32'(sb_k), 32'd8);
        chk("ws_done_pulses", 32'(fd_cnt), 32'd1);
        chk("ws_first_addr", 32'(first_addr), 32'h100);

        // Backpressure with latency 5
        begin_frame(0, 5, 32'h100);
        pixel_ready = 1'b0;
        pulse_start();
        repeat (20) @(posedge clock);
        #1;
        chk("bp_reads_stalled", 32'(s_acc_cnt), 32'd4);
        chk("bp_valid", 32'(pixel_valid), 32'd1);
        pixel_ready = 1'b1;
        wait_done(400);
        @(posedge clock); #1;
        chk("bp_max_inflight", 32'(max_inflight), 32'd4);
        chk("bp_pixels", 32'(sb_k), 32'd8);
        chk("bp_reads", 32'(s_acc_cnt), 32'd8);
        chk("bp_done_pulses", 32'(fd_cnt), 32'd1);

        // Reset after three reads accepted
        begin_frame(0, 4, 32'h100);
        pulse_start();
        begin
            bit got3 = 1'b0;
            for (int i = 0; i < 40 && !got3; i++) begin
                if (s_acc_cnt >= 3) got3 = 1'b1;
                else begin
                    @(posedge clock); #1;
                end
            end
            chk("mid_three_reads", 32'(got3), 32'd1);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        chk_reset_values("mid");
        repeat (8) @(posedge clock);
        #1;
        chk("mid_late_rsp_err", 32'(rsp_err), 32'd1);
        chk("mid_fifo_empty", 32'(pixel_valid), 32'd0);
        begin_frame(0, 1, 32'h100);
        pulse_start();
        wait_done(400);
        @(posedge clock); #1;
        chk("restart_first_addr", 32'(first_addr), 32'h100);
        chk("restart_pixels", 32'(sb_k), 32'd8);

`ifdef SCANOUT_DOUBLE_BUFFER_EN
        begin_frame(0, 1, 32'h200);
        buffer_select = 1'b1;
        pulse_start();
        buffer_select = 1'b0;
        wait_done(400);
        @(posedge clock); #1;
        chk("dbuf_first_addr", 32'(first_addr), 32'h200);
        chk("dbuf_pixels", 32'(sb_k), 32'd8);
`endif

        slave_en = 1'b0;
        sb_en    = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Avalon-MM read master that fetches one frame of 32-bit pixels from the framebuffer written by the depth-test stage and streams them in raster order to the display output. It is the read side of the framebuffer interface: same address map, same 26-bit byte address, same pixel word layout, with colour in bits [23:0]. A credit-based FIFO decouples memory latency and wait states from the display-side ready/valid handshake.

## Interface
Parameters:
- H_RES, 640, pixels per line (≥2)
- V_RES, 480, lines per frame (≥1)
- BASE_ADDR, 26'h0, byte address of pixel (0,0); must be 4-byte aligned
- FIFO_LOG2, 6, FIFO depth = 2**FIFO_LOG2 entries of 24 bits

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on the clock edge
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from the cycle after an accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is handed off
- master_address  out  26  byte address of the current read
- master_read  out  1  read request
- master_byteenable  out  4  constant 4'b1111
- master_readdata  in  32  read data; bits [23:0] used
- master_readdatavalid  in  1  read data strobe; responses return in order
- master_waitrequest  in  1  slave stall
- pixel_data  out  24  colour, FIFO head
- pixel_valid  out  1  FIFO non-empty
- pixel_ready  in  1  downstream accept
- pixel_sof  out  1  qualifies pixel_data as pixel (0,0)
- pixel_eol  out  1  qualifies pixel_data as the last pixel of a line
- rsp_err  out  1  sticky; set by readdatavalid with zero outstanding

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: master_read=0. On start: latch base, clear counters, enter FETCH.
- FETCH: assert master_read with master_address = base + 4·n, where n is the request index from 0 to H_RES·V_RES−1, when credits permit; otherwise deassert.
- A request is accepted when master_read && !master_waitrequest. On acceptance, n increments and outstanding increments.
- Address and read stay stable while waitrequest=1.
- Request gating: issue only while outstanding + fifo_count < 2**FIFO_LOG2. This guarantees a returning response never finds the FIFO full.
- Entering DRAIN: on acceptance of request n = H_RES·V_RES−1, go to DRAIN. master_read drops the next cycle.
- Responses: readdatavalid with outstanding>0 writes readdata[23:0] into the FIFO and decrements outstanding.
- Stray responses: readdatavalid with outstanding=0 is dropped and sets rsp_err. rsp_err is cleared only by reset.
- Same-cycle accept and response: outstanding is unchanged. Same-cycle FIFO write and read: fifo_count is unchanged.
- Output side: a transfer occurs when pixel_valid && pixel_ready.
- Output counters ox (0..H_RES−1) and oy (0..V_RES−1) advance on each transfer; ox wraps to 0 and increments oy.
- pixel_sof = (ox==0 && oy==0); pixel_eol = (ox==H_RES−1). Both are meaningful only while pixel_valid=1.
- DRAIN: when the final pixel (ox=H_RES−1, oy=V_RES−1) transfers, pulse frame_done and go to IDLE.
- start outside IDLE is ignored.
- Address arithmetic is 26-bit and wraps modulo 2**26. Pixel index width is $clog2(H_RES·V_RES).

## Timing
- Reset values:
  - master_read=0, master_address=BASE_ADDR, master_byteenable=4'hF
  - busy=0, frame_done=0, pixel_valid=0, pixel_sof=0, pixel_eol=0, pixel_data=0, rsp_err=0
  - state IDLE; all counters and FIFO cleared
- Reset mid-frame returns to IDLE in one cycle. Responses arriving after reset count as stray (rsp_err set).
- start at edge k: busy=1 and master_read=1 at k+1.
- With waitrequest=0 and credits available, one read is accepted per cycle, back-to-back.
- readdatavalid at edge k: pixel_valid=1 at k+1 (registered FIFO, 1-cycle write-to-read latency).
- frame_done is asserted the cycle after the final handoff, with busy=0 in the same cycle.
- A new start is accepted the cycle after frame_done.

## Configuration
- SCANOUT_DOUBLE_BUFFER_EN defined:
  - Adds parameter BASE_ADDR_B (default 26'h12C000) and input buffer_select (1 bit).
  - buffer_select is sampled with start: 0 selects BASE_ADDR, 1 selects BASE_ADDR_B, held for the whole frame.
- Undefined: no extra parameter or port; base is always BASE_ADDR.

## Test plan
- Basic frame: H_RES=4, V_RES=2, BASE_ADDR=26'h100, zero-latency slave returning data=addr, pixel_ready=1 -> reads at 0x100..0x11C; pixel_data 0x100..0x11C in order; sof on first; eol on 4th and 8th; one frame_done.
- Wait states: waitrequest=1 for 3 cycles on every read -> master_address and master_read held stable throughout; read count exactly 8.
- Backpressure: FIFO_LOG2=2, pixel_ready=0 for 20 cycles, slave latency 5 -> never more than 4 in flight plus buffered; no data lost; order preserved.
- Stray response: readdatavalid pulsed while IDLE -> rsp_err=1, FIFO remains empty.
- Reset mid-frame: reset=0 for 1 cycle after 3 reads accepted -> all outputs at reset values; following start fetches from 0x100 again.
- Double buffer (macro defined): start with buffer_select=1, BASE_ADDR_B=26'h200 -> first read at 0x200.
